// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serial_add_pkg
// Description : Shared definitions for the bit-serial add/subtract controller:
//               the default operand width and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Controller state encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/fullAdder.sv
`default_nettype none
// ============================================================================
// Module      : fullAdder
// Description : One-bit full adder cell, purely combinational.
// Ports       : x0, x1  - addend bits
//               cin     - carry in
//               s       - sum bit
//               cout    - carry out
// Revision    : 1.0 - initial release
// ============================================================================
module fullAdder (
  input  logic x0,
  input  logic x1,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_half;

  assign w_half = x0 ^ x1;
  assign s      = w_half ^ cin;
  assign cout   = (x0 & x1) | (cin & w_half);

endmodule : fullAdder
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial WIDTH-bit add/subtract controller. Operands are
//               latched on start, then one bit pair per clock (LSB first) is
//               pushed through a single full-adder cell. The carry lives in a
//               flop between bits; the sum is shifted in from the top. A done
//               pulse marks the result and flags valid.
// Ports       : clk      - clock, rising edge
//               reset    - synchronous active-high reset
//               start    - operation request, accepted only in IDLE
//               sub      - 0: a+b, 1: a-b (sampled with start)
//               a, b     - operands (sampled with start)
//               busy     - high while RUN or DONE
//               done     - one-cycle result-valid pulse
//               sum      - result, held until the next accepted start
//               cout     - carry out of MSB (subtract: 1 = no borrow)
//               overflow - two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q,  op_a_d;
  logic [WIDTH-1:0]   op_b_q,  op_b_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q,  cout_d;
  logic               ovf_q,   ovf_d;

  logic               cell_s;
  logic               cell_cout;
  logic [WIDTH-1:0]   shreg_next;

  // Single arithmetic cell: always looks at the current LSBs and carry flop.
  fullAdder u_cell (
    .x0   (op_a_q[0]),
    .x1   (op_b_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // Sum bits enter at the top so that after WIDTH shifts bit 0 is the LSB.
  assign shreg_next = {cell_s, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    shreg_d = shreg_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtract is A + ~B + 1: invert B and force the carry-in.
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          shreg_d = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        shreg_d = shreg_next;
        carry_d = cell_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // On the MSB step the carry flop holds the carry into the MSB,
          // so overflow is simply cin_msb XOR the final carry out. Results
          // are registered here so they are valid while done is high.
          sum_d   = shreg_next;
          cout_d  = cell_cout;
          ovf_d   = carry_q ^ cell_cout;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      shreg_q <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      shreg_q <= shreg_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH=8). A driver
//               issues operations and queues the expected result; a monitor
//               pops and compares whenever done is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           at;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input int at);
    exp_t e;
    int   ux, uy, sx, sy, ures, sres;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ures = s ? (ux - uy) : (ux + uy);
    sres = s ? (sx - sy) : (sx + sy);
    e.s  = ures[W-1:0];
    e.co = s ? (ux >= uy) : (ures > 255);
    e.ov = (sres > 127) || (sres < -128);
    e.at = at;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("cout", 32'(cout), 32'(e.co));
        check("overflow", 32'(overflow), 32'(e.ov));
        check("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Issue one operation; occupies exactly W+2 cycles from start to next start.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    @(negedge clk);
    a     = x;
    b     = y;
    sub   = s;
    start = 1'b1;
    exp_q.push_back(model(x, y, s, cyc + 1 + W));
    @(negedge clk);
    start = 1'b0;
    check("busy_in_run", 32'(busy), 32'd1);
    repeat (W) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Directed cases.
    do_op(8'h12, 8'h34, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0);
    do_op(8'h05, 8'h07, 1'b1);
    do_op(8'h80, 8'h01, 1'b1);
    do_op(8'h00, 8'h00, 1'b1);
    do_op(8'h80, 8'h80, 1'b0);

    // start while busy: second request with other operands must be ignored.
    @(negedge clk);
    a = 8'h21; b = 8'h43; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h21, 8'h43, 1'b0, cyc + 1 + W));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hF0; b = 8'h0F; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W - 2) @(negedge clk);
    check("idle_after_busy_start", 32'(busy), 32'd0);

    // Reset mid-RUN: partial result discarded, no done pulse, outputs cleared.
    @(negedge clk);
    a = 8'h55; b = 8'h66; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    check("midrun_reset_sum", 32'(sum), 32'd0);
    check("midrun_reset_cout", 32'(cout), 32'd0);
    check("midrun_reset_ovf", 32'(overflow), 32'd0);
    repeat (W + 2) @(negedge clk);
    check("no_done_after_reset", 32'(exp_q.size()), 32'd0);

    // Following start completes normally.
    do_op(8'h33, 8'h44, 1'b1);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_add_ctrl
`default_nettype wire
